// File: rtl/fetch_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
interface fetch_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          req;
  logic [AW-1:0] addr;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, output addr, input rvalid, input rdata);
  modport slave  (input req, input addr, output rvalid, output rdata);
endinterface

// File: rtl/fetch.sv
// Instruction-fetch stage: PC ownership, single-outstanding imem requests,
// one-entry stall buffer and redirect flush, feeding decode with pc/insn.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h8002_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  fetch_if.master     imem,
  output logic [31:0] pc,
  output logic [31:0] insn,
  output logic        insn_valid
);
  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_n;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_n;
  logic [XLEN-1:0]   buf_pc_q, buf_pc_n;
  logic [XLEN-1:0]   buf_insn_q, buf_insn_n;
  logic [XLEN-1:0]   pc_n, insn_n;
  logic              insn_valid_n;
  logic              req_n;
  logic [XLEN-1:0]   addr_n;
  logic              rsp;
  logic [XLEN-1:0]   target;

  // A response only counts while a request is actually being presented.
  assign rsp    = imem.req & imem.rvalid;
  assign target = redirect_pc & ~XLEN'(3);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= REQ;
      fetch_pc_q <= RESET_PC;
      buf_pc_q   <= '0;
      buf_insn_q <= '0;
      imem.req   <= 1'b0;
      imem.addr  <= RESET_PC;
      pc         <= '0;
      insn       <= '0;
      insn_valid <= 1'b0;
    end else begin
      state_q    <= state_n;
      fetch_pc_q <= fetch_pc_n;
      buf_pc_q   <= buf_pc_n;
      buf_insn_q <= buf_insn_n;
      imem.req   <= req_n;
      imem.addr  <= addr_n;
      pc         <= pc_n;
      insn       <= insn_n;
      insn_valid <= insn_valid_n;
    end
  end

  always_comb begin
    state_n      = state_q;
    fetch_pc_n   = fetch_pc_q;
    buf_pc_n     = buf_pc_q;
    buf_insn_n   = buf_insn_q;
    pc_n         = pc;
    insn_n       = insn;
    insn_valid_n = insn_valid;

    unique case (state_q)
      REQ: begin
        if (redirect) begin
          fetch_pc_n   = target;
          insn_n       = '0;
          insn_valid_n = 1'b0;
          // Without a same-cycle response the stale request must be drained.
          if (imem.req && !rsp) state_n = DRAIN;
        end else if (rsp) begin
          fetch_pc_n = fetch_pc_q + XLEN'(4);
          if (stall) begin
            buf_pc_n   = fetch_pc_q;
            buf_insn_n = imem.rdata;
            state_n    = HOLD;
          end else begin
            pc_n         = fetch_pc_q;
            insn_n       = imem.rdata;
            insn_valid_n = 1'b1;
          end
        end else if (!stall) begin
          insn_n       = '0;
          insn_valid_n = 1'b0;
        end
      end
      HOLD: begin
        if (redirect) begin
          fetch_pc_n   = target;
          insn_n       = '0;
          insn_valid_n = 1'b0;
          state_n      = REQ;
        end else if (!stall) begin
          pc_n         = buf_pc_q;
          insn_n       = buf_insn_q;
          insn_valid_n = 1'b1;
          state_n      = REQ;
        end
      end
      DRAIN: begin
        if (!stall) begin
          insn_n       = '0;
          insn_valid_n = 1'b0;
        end
        if (redirect) fetch_pc_n = target;
        if (rsp) state_n = REQ;
      end
      default: state_n = REQ;
    endcase

    // Request lines follow the next state; DRAIN keeps the stale address stable.
    req_n  = (state_n != HOLD);
    addr_n = (state_n == DRAIN) ? imem.addr : fetch_pc_n;
  end
endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: behavioural imem with programmable latency, rdata = ~addr.
module tb_fetch;
  localparam logic [31:0] R = 32'h8002_0000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [31:0] insn;
  logic        insn_valid;

  logic [2:0]  lat;
  logic [2:0]  cnt;

  int n_checks = 0;
  int n_errors = 0;

  fetch_if mem ();

  fetch dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (mem),
    .pc          (pc),
    .insn        (insn),
    .insn_valid  (insn_valid)
  );

  always #5 clock = ~clock;

  // Memory answers `lat` cycles after a request first appears (0 = same cycle).
  assign mem.rvalid = mem.req && (cnt == lat);
  assign mem.rdata  = ~mem.addr;

  always_ff @(posedge clock) begin
    if (!reset_n || !mem.req || mem.rvalid) cnt <= '0;
    else                                     cnt <= cnt + 3'd1;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e_pc, input logic [31:0] e_insn,
                         input logic e_valid);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".insn"}, insn, e_insn);
    chk({tag, ".valid"}, 32'(insn_valid), 32'(e_valid));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".req"}, 32'(mem.req), 32'd0);
    chk({tag, ".addr"}, mem.addr, R);
    chk_out(tag, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    int waited;
    logic [31:0] e_pc;

    reset_n     = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    lat         = 3'd0;

    // Reset, then zero-wait memory
    step();
    step();
    chk_reset("rst");
    reset_n = 1'b1;
    step();
    chk("first_req", 32'(mem.req), 32'd1);
    chk("first_addr", mem.addr, R);
    chk_out("first_bubble", 32'h0, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_out("zw", R + 32'(4 * k), ~(R + 32'(4 * k)), 1'b1);
    end

    // Two-cycle latency: one valid slot every third cycle
    lat = 3'd2;
    for (int k = 0; k < 6; k++) begin
      step();
      if (k % 3 == 2) begin
        e_pc = R + 32'd12 + 32'(4 * (k / 3));
        chk_out("lat2_valid", e_pc, ~e_pc, 1'b1);
      end else begin
        chk_out("lat2_bubble", R + 32'd8 + 32'(4 * (k / 3) * 4 / 4) + 32'(4 * (k / 3) == 0 ? 0 : 0),
                32'h0, 1'b0);
      end
    end

    // Stall while the response for R+8 arrives
    reset_n = 1'b0;
    lat     = 3'd0;
    step();
    reset_n = 1'b1;
    step();
    step();
    chk_out("st_pre0", R, ~R, 1'b1);
    step();
    chk_out("st_pre1", R + 32'd4, ~(R + 32'd4), 1'b1);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("st_req_low", 32'(mem.req), 32'd0);
      chk_out("st_hold", R + 32'd4, ~(R + 32'd4), 1'b1);
    end
    stall = 1'b0;
    step();
    chk_out("st_rel", R + 32'd8, ~(R + 32'd8), 1'b1);
    chk("st_rel_req", 32'(mem.req), 32'd1);
    chk("st_rel_addr", mem.addr, R + 32'd12);
    step();
    chk_out("st_next", R + 32'd12, ~(R + 32'd12), 1'b1);

    // Redirect one cycle into a 3-cycle-latency request
    lat = 3'd3;
    step();
    chk_out("rd_wait", R + 32'd12, 32'h0, 1'b0);
    redirect    = 1'b1;
    redirect_pc = 32'h8002_0103;
    step();
    redirect = 1'b0;
    chk_out("rd_bubble", R + 32'd12, 32'h0, 1'b0);
    chk("rd_stale_addr", mem.addr, R + 32'd16);
    step();
    chk("rd_drain_addr", mem.addr, R + 32'd16);
    step();
    chk("rd_new_addr", mem.addr, 32'h8002_0100);
    chk_out("rd_discard", R + 32'd12, 32'h0, 1'b0);
    waited = 0;
    while (!insn_valid && waited < 8) begin
      step();
      waited++;
    end
    chk("rd_latency", 32'(waited), 32'd4);
    chk_out("rd_target", 32'h8002_0100, ~32'h8002_0100, 1'b1);

    // Redirect coincident with a response while stalled
    lat         = 3'd0;
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h8002_0200;
    step();
    redirect = 1'b0;
    stall    = 1'b0;
    chk_out("rc_bubble", 32'h8002_0100, 32'h0, 1'b0);
    chk("rc_addr", mem.addr, 32'h8002_0200);
    step();
    chk_out("rc_target", 32'h8002_0200, ~32'h8002_0200, 1'b1);

    // Reset mid-DRAIN
    lat         = 3'd3;
    redirect    = 1'b1;
    redirect_pc = 32'h8002_0300;
    step();
    redirect = 1'b0;
    chk("dr_stale_addr", mem.addr, 32'h8002_0204);
    reset_n = 1'b0;
    step();
    chk_reset("rst_drain");
    reset_n = 1'b1;
    lat     = 3'd0;
    step();
    chk("dr_restart_addr", mem.addr, R);
    step();
    chk_out("dr_restart", R, ~R, 1'b1);

    // Reset mid-HOLD
    stall = 1'b1;
    step();
    chk("hd_req_low", 32'(mem.req), 32'd0);
    reset_n = 1'b0;
    step();
    chk_reset("rst_hold");
    stall   = 1'b0;
    reset_n = 1'b1;
    step();
    chk("hd_restart_addr", mem.addr, R);
    step();
    chk_out("hd_restart", R, ~R, 1'b1);

    // Address wrap from the top of the address space
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    chk("wr_addr", mem.addr, 32'hFFFF_FFFC);
    step();
    chk_out("wr_top", 32'hFFFF_FFFC, 32'h0000_0003, 1'b1);
    chk("wr_addr0", mem.addr, 32'h0);
    step();
    chk_out("wr_zero", 32'h0, 32'hFFFF_FFFF, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
